// File: rtl/memory2_stage_pkg.sv
// Payload types shared between the memory1, memory2 and writeback stages.
package memory2_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned LDOP_W = 3;

  typedef struct packed {
    logic              valid;
    logic              excp_valid;
    logic              is_ld;
    logic [LDOP_W-1:0] ld_op;
    logic [XLEN-1:0]   va;
    logic [XLEN-1:0]   ex_out;
  } memory1_memory2_pass_t;

  typedef struct packed {
    logic              valid;
    logic              excp_valid;
    logic              is_ld;
    logic [LDOP_W-1:0] ld_op;
    logic [XLEN-1:0]   va;
    logic [XLEN-1:0]   ex_mem_out;
  } memory2_writeback_pass_t;

endpackage

// File: rtl/memory2_stage.sv
// Memory2 stage: waits for the dcache load response, aligns/extends load data,
// and holds the response in a buffer while writeback is stalled.
module memory2_stage
  import memory2_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    stall_i,
  output logic                    stall_o,
  input  memory1_memory2_pass_t   pass_in,
  input  logic                    dcache_rvalid,
  input  logic [XLEN-1:0]         dcache_rdata,
  output memory2_writeback_pass_t pass_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state;
  state_t                state_n;
  memory1_memory2_pass_t pass_in_r;
  logic                  drop_r;
  logic [XLEN-1:0]       rdata_buf;

  logic                  need_wait;
  logic                  accept;
  logic                  data_ready;
  logic                  drop_set;
  logic [XLEN-1:0]       ld_word;
  logic [XLEN-1:0]       ld_data;
  logic [1:0]            off;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign need_wait  = pass_in_r.valid & pass_in_r.is_ld & ~pass_in_r.excp_valid;
  assign accept     = dcache_rvalid & ~drop_r &
                      (((state == IDLE) & need_wait) | (state == WAIT));
  assign data_ready = (state == HOLD) | accept;
  assign stall_o    = stall_i | (need_wait & ~data_ready);
  // A flushed load whose response is still outstanding must have that response swallowed.
  assign drop_set   = flush_i & ((state == WAIT) | ((state == IDLE) & need_wait & ~accept));

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin : next_state
    state_n = state;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (need_wait) begin
            if (!accept)      state_n = WAIT;
            else if (stall_i) state_n = HOLD;
          end
        end
        WAIT:    if (accept) state_n = stall_i ? HOLD : IDLE;
        HOLD:    if (!stall_i) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : input_reg
    if (!rst_n)        pass_in_r       <= '0;
    else if (flush_i)  pass_in_r.valid <= 1'b0;
    else if (!stall_o) pass_in_r       <= pass_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin : drop_reg
    if (!rst_n)                       drop_r <= 1'b0;
    else if (drop_set)                drop_r <= 1'b1;
    else if (drop_r && dcache_rvalid) drop_r <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin : rdata_reg
    if (!rst_n)      rdata_buf <= '0;
    else if (accept) rdata_buf <= dcache_rdata;
  end

  // Load alignment and sign/zero extension.
  always_comb begin : load_extract
    ld_word = (state == HOLD) ? rdata_buf : dcache_rdata;
    off     = pass_in_r.va[1:0];
    ld_byte = ld_word[7:0];
    unique case (off)
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    ld_half = off[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (pass_in_r.ld_op)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin : out_payload
    pass_out            = '0;
    pass_out.valid      = pass_in_r.valid & ~stall_o;
    pass_out.excp_valid = pass_in_r.excp_valid;
    pass_out.is_ld      = pass_in_r.is_ld;
    pass_out.ld_op      = pass_in_r.ld_op;
    pass_out.va         = pass_in_r.va;
    pass_out.ex_mem_out = need_wait ? ld_data : pass_in_r.ex_out;
  end

endmodule

// File: tb/tb_memory2_stage.sv
// Scoreboard bench for memory2_stage: a transaction-level environment model
// drives memory1/dcache/writeback and predicts stall and retired payloads.
module tb_memory2_stage;
  import memory2_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    flush_i = 1'b0;
  logic                    stall_i = 1'b0;
  logic                    stall_o;
  memory1_memory2_pass_t   pass_in = '0;
  logic                    dcache_rvalid = 1'b0;
  logic [31:0]             dcache_rdata = '0;
  memory2_writeback_pass_t pass_out;

  memory2_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i),
    .stall_o(stall_o), .pass_in(pass_in), .dcache_rvalid(dcache_rvalid),
    .dcache_rdata(dcache_rdata), .pass_out(pass_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    memory1_memory2_pass_t ins;
    int                    delay;   // cycles after entry until the response
    int                    hold;    // stall_i cycles starting at the response cycle
    bit                    stale;   // drive a stray response in the entry cycle
    logic [31:0]           sdata;
    logic [31:0]           rdata;
  } item_t;

  typedef struct {
    logic [31:0] va;
    logic [31:0] data;
  } exp_t;

  item_t pend[$];
  exp_t  sbq[$];
  item_t pres, stg;
  int    stg_cnt = 0;
  bit    flush_now = 0, flush_req = 0, stray_once = 0;
  int    rst_cnt = 3;
  bit    exp_stall = 0, exp_valid = 0, chk_en = 0, done = 0;
  bit    rand_stall = 1, rand_stray = 0;
  int    drain_to = 0;
  int    checks = 0, errors = 0, cycles = 0;
  exp_t  e;

  function automatic bit waits(input memory1_memory2_pass_t p);
    return p.valid && p.is_ld && !p.excp_valid;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] va,
                                           input logic [31:0] w);
    int unsigned off, b, h;
    off = 32'(va[1:0]);
    b   = (w >> (8 * off)) % 256;
    h   = (w >> (16 * (off / 2))) % 65536;
    case (op)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic item_t bubble();
    item_t it;
    it.ins = '0;
    it.ins.va = $urandom;
    it.ins.ex_out = $urandom;
    it.delay = 0; it.hold = 0; it.stale = 0; it.sdata = '0; it.rdata = '0;
    return it;
  endfunction

  function automatic item_t mk(input bit ld, input bit ex, input logic [2:0] op,
                               input logic [31:0] va, input logic [31:0] exo,
                               input int dly, input int hld, input logic [31:0] rd);
    item_t it;
    it = bubble();
    it.ins.valid = 1'b1; it.ins.is_ld = ld; it.ins.excp_valid = ex;
    it.ins.ld_op = op; it.ins.va = va; it.ins.ex_out = exo;
    it.delay = dly; it.hold = hld; it.rdata = rd;
    return it;
  endfunction

  // One clock of the environment: retire/advance the modelled stage, then drive inputs.
  task automatic tick();
    bit wait_now, take;
    take = 0;
    @(posedge clk);
    if (!rst_n || flush_now) stg.ins.valid = 1'b0;
    else if (!exp_stall) begin stg = pres; stg_cnt = 0; take = 1; end
    else stg_cnt++;
    #1;
    if (take) pres = (pend.size() > 0) ? pend.pop_front() : bubble();
    if (rst_cnt > 0) begin rst_n = 1'b0; rst_cnt--; stg.ins.valid = 1'b0; end
    else rst_n = 1'b1;
    flush_now = flush_req; flush_req = 0; flush_i = flush_now;
    wait_now = waits(stg.ins);
    if (stg.ins.valid && stg_cnt >= stg.delay && stg_cnt < stg.delay + stg.hold) stall_i = 1'b1;
    else stall_i = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    dcache_rvalid = 1'b0;
    dcache_rdata  = $urandom;
    if (wait_now && stg_cnt == stg.delay) begin
      dcache_rvalid = 1'b1; dcache_rdata = stg.rdata;
    end else if (stg.ins.valid && stg.stale && stg_cnt == 0) begin
      dcache_rvalid = 1'b1; dcache_rdata = stg.sdata;
    end else if (!wait_now && stray_once) begin
      dcache_rvalid = 1'b1; stray_once = 0;
    end else if (!wait_now && rand_stray && $urandom_range(0, 3) == 0) begin
      dcache_rvalid = 1'b1;
    end
    pass_in   = pres.ins;
    exp_stall = stall_i || (wait_now && stg_cnt < stg.delay);
    exp_valid = stg.ins.valid && !exp_stall;
    if (exp_valid) begin
      e.va   = stg.ins.va;
      e.data = wait_now ? ref_load(stg.ins.ld_op, stg.ins.va, stg.rdata) : stg.ins.ex_out;
      sbq.push_back(e);
    end
    chk_en = 1;
  endtask

  function automatic bit busy();
    return pend.size() > 0 || pres.ins.valid || stg.ins.valid;
  endfunction

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (busy() && n < limit) begin tick(); n++; end
    if (busy()) drain_to++;
  endtask

  task automatic wait_in_wait(input int limit);
    int n;
    n = 0;
    while (!(stg.ins.valid && stg_cnt >= 1) && n < limit) begin tick(); n++; end
    if (!(stg.ins.valid && stg_cnt >= 1)) drain_to++;
  endtask

  // Monitor: compares stall/valid each cycle and pops the scoreboard on every retirement.
  always @(negedge clk) begin
    cycles++;
    if (chk_en) begin
      checks++;
      if (stall_o !== exp_stall) begin
        errors++;
        $display("FAIL stall_o got %0b expected %0b at %0t", stall_o, exp_stall, $time);
      end
      checks++;
      if (pass_out.valid !== exp_valid) begin
        errors++;
        $display("FAIL valid got %0b expected %0b at %0t", pass_out.valid, exp_valid, $time);
      end
      if (pass_out.valid === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got va=%h data=%h expected none", pass_out.va,
                   pass_out.ex_mem_out);
        end else begin
          e = sbq.pop_front();
          if (pass_out.ex_mem_out !== e.data || pass_out.va !== e.va) begin
            errors++;
            $display("FAIL payload got va=%h data=%h expected va=%h data=%h at %0t",
                     pass_out.va, pass_out.ex_mem_out, e.va, e.data, $time);
          end
        end
      end
    end
    if (done || cycles > 40000) begin
      checks++;
      if (sbq.size() != 0 || drain_to != 0 || !done) begin
        errors++;
        $display("FAIL completion got pending=%0d timeouts=%0d done=%0b expected 0 0 1",
                 sbq.size(), drain_to, done);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    pres = bubble();
    stg  = bubble();
    repeat (6) tick();
    rand_stall = 0;

    pend.push_back(mk(1, 0, 3'd2, 32'h1000, 32'h0, 0, 0, 32'hDEAD_BEEF));
    pend.push_back(mk(1, 0, 3'd0, 32'h1003, 32'h0, 3, 0, 32'h8000_0000));
    pend.push_back(mk(1, 0, 3'd5, 32'h1002, 32'h0, 0, 2, 32'hBEEF_1234));
    pend.push_back(mk(0, 0, 3'd0, 32'h2000, 32'h5, 0, 0, 32'h0));
    pend[3].stale = 1; pend[3].sdata = 32'hCAFE_0001;
    pend.push_back(mk(1, 1, 3'd2, 32'h3000, 32'h77, 0, 0, 32'h0));
    pend.push_back(mk(1, 0, 3'd1, 32'h4002, 32'h0, 1, 0, 32'h8001_7FFF));
    pend.push_back(mk(1, 0, 3'd4, 32'h4001, 32'h0, 2, 1, 32'h0000_9A00));
    drain(200);

    // Flush while waiting: the stale response must be dropped.
    pend.push_back(mk(1, 0, 3'd2, 32'h5000, 32'h0, 50, 0, 32'h3333_3333));
    wait_in_wait(50);
    flush_req = 1;
    pend.push_back(mk(1, 0, 3'd2, 32'h6000, 32'h0, 1, 0, 32'h2222_2222));
    pend[0].stale = 1; pend[0].sdata = 32'h1111_1111;
    drain(200);

    // Reset while waiting: no drop may survive.
    pend.push_back(mk(1, 0, 3'd2, 32'h7000, 32'h0, 50, 0, 32'h4444_4444));
    wait_in_wait(50);
    rst_cnt = 2;
    repeat (3) tick();
    pend.push_back(mk(1, 0, 3'd2, 32'h8000, 32'h0, 0, 0, 32'h5555_5555));
    drain(200);
    stray_once = 1;
    repeat (3) tick();

    rand_stall = 1; rand_stray = 1;
    for (int i = 0; i < 400; i++) begin
      item_t it;
      it = mk($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, 3'($urandom),
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
      it.ins.valid = ($urandom_range(0, 7) != 0);
      pend.push_back(it);
    end
    drain(20000);
    repeat (2) tick();
    done = 1;
  end

endmodule

// File: doc/memory2_stage.md
MEMORY2_STAGE -- requirements
Module: memory2_stage

Interface
Parameters: none.
REQ-001 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush
- stall_i  in  1  stall from writeback
- stall_o  out  1  stall to memory1
- pass_in  in  memory1_memory2_pass_t  upstream payload; fields used: valid, excp_valid, is_ld, ld_op[2:0], va[31:0], ex_out[31:0]
- dcache_rvalid  in  1  load response valid, one cycle per response
- dcache_rdata  in  32  raw aligned load word
- pass_out  out  memory2_writeback_pass_t  downstream payload

Function
REQ-002 Input register pass_in_r SHALL load pass_in on posedge when ~stall_o; pass_in_r.valid SHALL clear on flush_i, flush taking priority over load.
REQ-003 need_wait SHALL equal pass_in_r.valid & pass_in_r.is_ld & ~pass_in_r.excp_valid.
REQ-004 FSM states SHALL be IDLE, WAIT, HOLD.
- IDLE: need_wait and no response this cycle -> WAIT. need_wait and accepted response with stall_i=1 -> HOLD.
- WAIT: accepted response with stall_i=0 -> IDLE. Accepted response with stall_i=1 -> HOLD.
- HOLD: stall_i=0 -> IDLE.
REQ-005 A response SHALL be accepted when dcache_rvalid=1 and drop_r=0 and the state is IDLE with need_wait=1, or WAIT.
REQ-006 An accepted response SHALL be latched into rdata_buf (32 bit); HOLD SHALL source load data from rdata_buf; IDLE and WAIT SHALL source it from dcache_rdata.
REQ-007 stall_o SHALL equal stall_i | (need_wait & ~data_ready), where data_ready = (state==HOLD) | accepted response this cycle. Load-to-writeback latency SHALL be 0 extra cycles if the response arrives in the entry cycle, else equal to the response delay.
REQ-008 flush_i in WAIT, or in IDLE with need_wait=1 and no response accepted, SHALL set drop_r.
- drop_r=1: the next dcache_rvalid SHALL be discarded and drop_r cleared.
- The FSM SHALL go to IDLE on any flush.
REQ-009 Load extraction SHALL use off=va[1:0]:
- ld_op 0 LD.B: sign-extend byte[off].
- ld_op 1 LD.H: sign-extend half[off[1]].
- ld_op 2 LD.W: full word.
- ld_op 4 LD.BU: zero-extend byte[off].
- ld_op 5 LD.HU: zero-extend half[off[1]].
- Other ld_op values SHALL yield the full word.
REQ-010 pass_out SHALL copy all pass_in_r fields, with these overrides:
- pass_out.ex_mem_out = extracted load data when need_wait, else ex_out.
- pass_out.valid = pass_in_r.valid & ~stall_o.
REQ-011 Stores and non-loads SHALL never assert stall_o beyond stall_i. Excepting loads SHALL pass through without waiting.
REQ-012 A dcache_rvalid arriving in IDLE with need_wait=0 and drop_r=0 SHALL be ignored.

Reset
REQ-013 On rst_n low, asynchronously:
- state=IDLE, pass_in_r.valid=0, drop_r=0, rdata_buf=0.
- Hence pass_out.valid=0 and stall_o=stall_i.
REQ-014 Reset mid-WAIT or mid-HOLD SHALL discard the pending load with no retained drop.

Verification
REQ-015 Directed scenarios:
- LD.W va=0x1000, rdata=0xDEADBEEF in entry cycle, stall_i=0 -> same cycle ex_mem_out=0xDEADBEEF, valid=1, stall_o=0.
- LD.B va=0x1003, rdata=0x80000000, response 3 cycles late -> stall_o=1 for 3 cycles, then ex_mem_out=0xFFFFFF80, valid=1 once.
- LD.HU va=0x1002, rdata=0xBEEF1234, stall_i=1 at response for 2 cycles -> HOLD, then ex_mem_out=0x0000BEEF from buffer after stall_i drops.
- LD in WAIT, flush_i pulse, new LD.W enters, stale rdata=0x11111111 then rdata=0x22222222 -> first discarded, ex_mem_out=0x22222222.
- Store or ALU op ex_out=0x5 with dcache_rvalid=1 -> no stall, ex_mem_out=0x5.
- rst_n low during WAIT -> valid=0, IDLE; next response with no load ignored.
